// File: rtl/ni_credit_tx.sv
// Credit-based flit transmitter: upstream flits are buffered in a small FWFT queue
// and forwarded downstream one per cycle while the downstream credit count is non-zero.
module ni_credit_tx #(
  parameter int DW          = 32,
  parameter int CREDIT_INIT = 8,
  parameter int QDEPTH_LOG  = 2,
  parameter int TOTAL_FLITS = 10000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic [31:0]   credit_upd_i,
  output logic [7:0]    credit_o,
  output logic [31:0]   sent_cnt_o,
  output logic [31:0]   stall_cnt_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    state_o
);

  localparam int                DEPTH      = 1 << QDEPTH_LOG;
  localparam int                PW         = (QDEPTH_LOG > 0) ? QDEPTH_LOG : 1;
  localparam logic [QDEPTH_LOG:0] DEPTH_C  = (QDEPTH_LOG + 1)'(DEPTH);
  localparam logic [7:0]        CREDIT_MAX = 8'(CREDIT_INIT);
  localparam logic [31:0]       TOTAL_C    = 32'(TOTAL_FLITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [QDEPTH_LOG:0]  count_q, count_d;
  logic [7:0]           credit_q, credit_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic [31:0]          sent_q, sent_d;
  logic [31:0]          stall_q, stall_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic [32:0]          credit_sum;
  logic                 credit_over;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Upstream handshake: a flit transfers on a rising edge where valid_i and ready_o
  // are both high. ready_o depends only on queue occupancy and reset, never on
  // valid_i, so a pop in the same cycle does not open a slot at full.
  assign full    = (count_q == DEPTH_C);
  assign ready_o = ~full & ~rst_i;
  assign push    = valid_i & ready_o;
  assign pop     = (state_q == ST_SEND);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A pop only happens with credit_q >= 1, so the 33-bit sum never underflows and
  // keeps the full width of credit_upd_i in the overflow comparison.
  always_comb begin
    credit_sum  = {25'd0, credit_q} + {1'b0, credit_upd_i} - {32'd0, pop};
    credit_over = (credit_sum > {25'd0, CREDIT_MAX});
    credit_d    = credit_over ? CREDIT_MAX : credit_sum[7:0];
    err_d       = err_q | credit_over;
  end

  // State reflects the queue and credit values that will hold next cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (count_d == '0)        state_d = ST_IDLE;
    else if (credit_d == 8'd0) state_d = ST_STALL;
    else                       state_d = ST_SEND;
  end

  always_comb begin
    valid_d = pop;
    data_d  = data_q;
    if (pop) data_d = mem_q[rd_ptr_q];
    sent_d  = sent_q + {31'd0, valid_q};
    stall_d = stall_q;
    if ((state_q == ST_STALL) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    done_d  = done_q | (valid_q & ((sent_q + 32'd1) == TOTAL_C));
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= CREDIT_MAX;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sent_q   <= '0;
      stall_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sent_q   <= sent_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign credit_o    = credit_q;
  assign sent_cnt_o  = sent_q;
  assign stall_cnt_o = stall_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule
